forwarding_unit_param: RTL and testbench

Parametrised operand-forwarding and load-use hazard unit between Decode and Execute. Tracks NSTAGE in-flight producer stages in a shift table of {valid, dest, writes, load}. Resolves each Decode source operand from the youngest valid writing producer, or from the register file, and registers the result into the ID/EX operand registers. Generates a combinational multi-cycle load-use stall, inserts bubbles into the table, ignores register 0, and counts stall cycles.

---
 rtl/forwarding_unit_param.sv | 122 ++++++++++++
 tb/tb_forwarding_unit_param.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/forwarding_unit_param.sv
// Operand forwarding and load-use hazard unit between Decode and Execute.
// A shift table of in-flight producers selects each operand's youngest source and raises the load-use stall.
module forwarding_unit_param #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NSTAGE   = 3,
    parameter int LOAD_LAT = 2,
    parameter int CNT_W    = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     id_valid,
    input  logic [ADDR_W-1:0]        id_regdest,
    input  logic                     id_writereg,
    input  logic                     id_load,
    input  logic                     id_usea,
    input  logic                     id_useb,
    input  logic [ADDR_W-1:0]        id_addra,
    input  logic [ADDR_W-1:0]        id_addrb,
    input  logic [DATA_W-1:0]        id_rega,
    input  logic [DATA_W-1:0]        id_regb,
    input  logic [NSTAGE*DATA_W-1:0] st_fw_wbvalue,
    output logic [DATA_W-1:0]        fw_id_rega,
    output logic [DATA_W-1:0]        fw_id_regb,
    output logic                     fw_id_valid,
    output logic                     fw_if_id_stall,
    output logic [1:0]               fw_src_a,
    output logic [1:0]               fw_src_b,
    output logic [CNT_W-1:0]         fw_stall_count
);

    logic [NSTAGE-1:0] ent_vld;
    logic [NSTAGE-1:0] ent_wr;
    logic [NSTAGE-1:0] ent_ld;
    logic [ADDR_W-1:0] ent_dest [NSTAGE];

    logic [DATA_W-1:0] opa_p0, opb_p0;
    logic [1:0]        srca_p0, srcb_p0;
    logic              early_ld_a, early_ld_b;
    logic              stall;

    function automatic logic hit(input logic vld, input logic wr,
                                 input logic [ADDR_W-1:0] dest,
                                 input logic [ADDR_W-1:0] addr,
                                 input logic use_x);
        return vld && wr && use_x && (dest == addr) && (dest != '0);
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val);
        return (val == '1) ? val : val + CNT_W'(1);
    endfunction

    // Decode: scan oldest to youngest so the youngest matching producer wins
    always_comb begin
        opa_p0     = id_rega;
        opb_p0     = id_regb;
        srca_p0    = '0;
        srcb_p0    = '0;
        early_ld_a = 1'b0;
        early_ld_b = 1'b0;
        for (int i = NSTAGE - 1; i >= 0; i--) begin
            if (hit(ent_vld[i], ent_wr[i], ent_dest[i], id_addra, id_usea)) begin
                opa_p0     = st_fw_wbvalue[i*DATA_W +: DATA_W];
                srca_p0    = 2'(i + 1);
                early_ld_a = ent_ld[i] && (i < LOAD_LAT - 1);
            end
            if (hit(ent_vld[i], ent_wr[i], ent_dest[i], id_addrb, id_useb)) begin
                opb_p0     = st_fw_wbvalue[i*DATA_W +: DATA_W];
                srcb_p0    = 2'(i + 1);
                early_ld_b = ent_ld[i] && (i < LOAD_LAT - 1);
            end
        end
        stall = id_valid && (early_ld_a || early_ld_b);
    end

    assign fw_if_id_stall = stall;

    // Producer table: a stalled Decode enters Execute as a bubble
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ent_vld <= '0;
            ent_wr  <= '0;
            ent_ld  <= '0;
            for (int i = 0; i < NSTAGE; i++) ent_dest[i] <= '0;
        end else begin
            for (int i = 1; i < NSTAGE; i++) begin
                ent_vld[i]  <= ent_vld[i-1];
                ent_wr[i]   <= ent_wr[i-1];
                ent_ld[i]   <= ent_ld[i-1];
                ent_dest[i] <= ent_dest[i-1];
            end
            ent_vld[0]  <= id_valid && !stall;
            ent_wr[0]   <= id_writereg;
            ent_ld[0]   <= id_load;
            ent_dest[0] <= id_regdest;
        end
    end

    // ID/EX boundary: operands hold while Decode is stalled
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fw_id_rega     <= '0;
            fw_id_regb     <= '0;
            fw_src_a       <= '0;
            fw_src_b       <= '0;
            fw_id_valid    <= 1'b0;
            fw_stall_count <= '0;
        end else begin
            if (stall) begin
                fw_id_valid    <= 1'b0;
                fw_stall_count <= sat_inc(fw_stall_count);
            end else begin
                fw_id_rega  <= opa_p0;
                fw_id_regb  <= opb_p0;
                fw_src_a    <= srca_p0;
                fw_src_b    <= srcb_p0;
                fw_id_valid <= id_valid;
            end
        end
    end

endmodule

// File: tb/tb_forwarding_unit_param.sv
// Directed bench for forwarding_unit_param: one instance with LOAD_LAT=2, one with LOAD_LAT=3 and a 2-bit counter.
// Inputs are shared; a select picks which instance is being checked in each phase.
module tb_forwarding_unit_param;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NS = 3;

    logic              clock = 1'b0;
    logic              reset;
    logic              id_valid, id_writereg, id_load, id_usea, id_useb;
    logic [AW-1:0]     id_regdest, id_addra, id_addrb;
    logic [DW-1:0]     id_rega, id_regb;
    logic [NS*DW-1:0]  st_fw_wbvalue;

    logic [DW-1:0] a_rega, a_regb, b_rega, b_regb;
    logic          a_valid, a_stall, b_valid, b_stall;
    logic [1:0]    a_srca, a_srcb, b_srca, b_srcb;
    logic [15:0]   a_cnt;
    logic [1:0]    b_cnt;

    forwarding_unit_param #(.DATA_W(DW), .ADDR_W(AW), .NSTAGE(NS), .LOAD_LAT(2), .CNT_W(16)) u_a (
        .clock(clock), .reset(reset), .id_valid(id_valid), .id_regdest(id_regdest),
        .id_writereg(id_writereg), .id_load(id_load), .id_usea(id_usea), .id_useb(id_useb),
        .id_addra(id_addra), .id_addrb(id_addrb), .id_rega(id_rega), .id_regb(id_regb),
        .st_fw_wbvalue(st_fw_wbvalue), .fw_id_rega(a_rega), .fw_id_regb(a_regb),
        .fw_id_valid(a_valid), .fw_if_id_stall(a_stall), .fw_src_a(a_srca), .fw_src_b(a_srcb),
        .fw_stall_count(a_cnt));

    forwarding_unit_param #(.DATA_W(DW), .ADDR_W(AW), .NSTAGE(NS), .LOAD_LAT(3), .CNT_W(2)) u_b (
        .clock(clock), .reset(reset), .id_valid(id_valid), .id_regdest(id_regdest),
        .id_writereg(id_writereg), .id_load(id_load), .id_usea(id_usea), .id_useb(id_useb),
        .id_addra(id_addra), .id_addrb(id_addrb), .id_rega(id_rega), .id_regb(id_regb),
        .st_fw_wbvalue(st_fw_wbvalue), .fw_id_rega(b_rega), .fw_id_regb(b_regb),
        .fw_id_valid(b_valid), .fw_if_id_stall(b_stall), .fw_src_a(b_srca), .fw_src_b(b_srcb),
        .fw_stall_count(b_cnt));

    always #5 clock = ~clock;

    bit          sel;
    logic [31:0] o_rega, o_regb, o_cnt;
    logic        o_valid, o_stall;
    logic [1:0]  o_srca, o_srcb;
    assign o_rega  = sel ? b_rega  : a_rega;
    assign o_regb  = sel ? b_regb  : a_regb;
    assign o_valid = sel ? b_valid : a_valid;
    assign o_stall = sel ? b_stall : a_stall;
    assign o_srca  = sel ? b_srca  : a_srca;
    assign o_srcb  = sel ? b_srcb  : a_srcb;
    assign o_cnt   = sel ? 32'(b_cnt) : 32'(a_cnt);

    typedef struct packed {
        logic        valid;
        logic [31:0] rega;
        logic [1:0]  srca;
        logic [31:0] regb;
        logic [1:0]  srcb;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    function automatic exp_t mk(input logic v, input logic [31:0] ra, input logic [1:0] sa,
                                input logic [31:0] rb, input logic [1:0] sbv);
        exp_t e;
        e.valid = v; e.rega = ra; e.srca = sa; e.regb = rb; e.srcb = sbv;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [4:0] dest, input logic wr, input logic ld,
                         input logic ua, input logic [4:0] aa, input logic ub, input logic [4:0] ab);
        id_valid = v; id_regdest = dest; id_writereg = wr; id_load = ld;
        id_usea = ua; id_addra = aa; id_useb = ub; id_addrb = ab;
    endtask

    // Check the combinational stall, queue the expected ID/EX contents, clock, then compare.
    task automatic step(input string tag, input logic exp_stall, input exp_t e);
        exp_t got;
        #1;
        chk($sformatf("%s.stall", tag), 32'(o_stall), 32'(exp_stall));
        sb.push_back(e);
        @(posedge clock);
        #1;
        got = sb.pop_front();
        chk($sformatf("%s.valid", tag), 32'(o_valid), 32'(got.valid));
        chk($sformatf("%s.rega", tag), o_rega, got.rega);
        chk($sformatf("%s.srca", tag), 32'(o_srca), 32'(got.srca));
        chk($sformatf("%s.regb", tag), o_regb, got.regb);
        chk($sformatf("%s.srcb", tag), 32'(o_srcb), 32'(got.srcb));
    endtask

    task automatic chk_zero(input string tag);
        chk($sformatf("%s.rega", tag), o_rega, 32'h0);
        chk($sformatf("%s.regb", tag), o_regb, 32'h0);
        chk($sformatf("%s.srca", tag), 32'(o_srca), 32'h0);
        chk($sformatf("%s.srcb", tag), 32'(o_srcb), 32'h0);
        chk($sformatf("%s.valid", tag), 32'(o_valid), 32'h0);
        chk($sformatf("%s.stall", tag), 32'(o_stall), 32'h0);
        chk($sformatf("%s.cnt", tag), o_cnt, 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        sel = 1'b0;
        reset = 1'b0;
        drive(1'b1, 5'd7, 1'b1, 1'b1, 1'b1, 5'd7, 1'b1, 5'd7);
        id_rega = 32'h1;
        id_regb = 32'h2;
        st_fw_wbvalue = {32'h33, 32'h22, 32'hAA};
        repeat (2) @(posedge clock);
        #1;
        sel = 1'b0; #0 chk_zero("rst_a");
        sel = 1'b1; #0 chk_zero("rst_b");
        sel = 1'b0;
        #2 reset = 1'b1;
        drive(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
        @(posedge clock);
        #1;

        // EX forwarding
        drive(1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
        step("ex_prod", 1'b0, mk(1'b1, 32'h1, 2'd0, 32'h2, 2'd0));
        drive(1'b1, 5'd4, 1'b1, 1'b0, 1'b1, 5'd3, 1'b0, 5'd0);
        step("ex_fwd", 1'b0, mk(1'b1, 32'hAA, 2'd1, 32'h2, 2'd0));

        // Priority: youngest writer wins, invalid and non-writing entries never match
        st_fw_wbvalue = {32'h33, 32'h22, 32'h11};
        drive(1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
        step("pri_w5a", 1'b0, mk(1'b1, 32'h1, 2'd0, 32'h2, 2'd0));
        drive(1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
        step("pri_w6", 1'b0, mk(1'b1, 32'h1, 2'd0, 32'h2, 2'd0));
        drive(1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
        step("pri_w5b", 1'b0, mk(1'b1, 32'h1, 2'd0, 32'h2, 2'd0));
        drive(1'b1, 5'd9, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 5'd0);
        step("pri_young", 1'b0, mk(1'b1, 32'h11, 2'd1, 32'h2, 2'd0));
        drive(1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
        step("pri_w5c", 1'b0, mk(1'b1, 32'h1, 2'd0, 32'h2, 2'd0));
        drive(1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
        step("pri_nowr", 1'b0, mk(1'b1, 32'h1, 2'd0, 32'h2, 2'd0));
        drive(1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
        step("pri_bubble", 1'b0, mk(1'b0, 32'h1, 2'd0, 32'h2, 2'd0));
        drive(1'b1, 5'd8, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 5'd0);
        step("pri_old", 1'b0, mk(1'b1, 32'h33, 2'd3, 32'h2, 2'd0));

        // r0 is never forwarded (even from a load); unused source reads the regfile
        drive(1'b1, 5'd0, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0);
        step("r0_lw", 1'b0, mk(1'b1, 32'h1, 2'd0, 32'h2, 2'd0));
        id_rega = 32'h5555;
        id_regb = 32'h6666;
        drive(1'b1, 5'd10, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 5'd8);
        step("r0_nouse", 1'b0, mk(1'b1, 32'h5555, 2'd0, 32'h6666, 2'd0));
        id_rega = 32'h1;
        id_regb = 32'h2;
        drive(1'b1, 5'd12, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 5'd8);
        step("fwd_b", 1'b0, mk(1'b1, 32'h1, 2'd0, 32'h33, 2'd3));

        // Load-use with LOAD_LAT=2: one stall cycle, then forward from slice 1
        drive(1'b1, 5'd7, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0);
        step("lu_lw", 1'b0, mk(1'b1, 32'h1, 2'd0, 32'h2, 2'd0));
        drive(1'b1, 5'd11, 1'b1, 1'b0, 1'b1, 5'd7, 1'b1, 5'd7);
        step("lu_stall", 1'b1, mk(1'b0, 32'h1, 2'd0, 32'h2, 2'd0));
        chk("lu_cnt1", o_cnt, 32'd1);
        step("lu_fwd", 1'b0, mk(1'b1, 32'h22, 2'd2, 32'h22, 2'd2));
        chk("lu_cnt2", o_cnt, 32'd1);

        // Reset in the middle of a stall
        drive(1'b1, 5'd7, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0);
        step("mr_lw", 1'b0, mk(1'b1, 32'h1, 2'd0, 32'h2, 2'd0));
        drive(1'b1, 5'd11, 1'b1, 1'b0, 1'b1, 5'd7, 1'b0, 5'd0);
        #1;
        chk("mr_stall_on", 32'(o_stall), 32'd1);
        #2 reset = 1'b0;
        #1 chk_zero("mr_rst");
        #1 reset = 1'b1;
        step("mr_new", 1'b0, mk(1'b1, 32'h1, 2'd0, 32'h2, 2'd0));

        // Second instance: LOAD_LAT=3, 2-bit saturating counter
        sel = 1'b1;
        reset = 1'b0;
        #3 reset = 1'b1;
        @(posedge clock);
        #1;
        chk("b_cnt0", o_cnt, 32'd0);
        for (int r = 0; r < 3; r++) begin
            drive(1'b1, 5'd7, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0);
            step($sformatf("b%0d_lw", r), 1'b0, mk(1'b1, 32'h1, 2'd0, 32'h2, 2'd0));
            drive(1'b1, 5'd11, 1'b1, 1'b0, 1'b1, 5'd7, 1'b0, 5'd0);
            step($sformatf("b%0d_st1", r), 1'b1, mk(1'b0, 32'h1, 2'd0, 32'h2, 2'd0));
            step($sformatf("b%0d_st2", r), 1'b1, mk(1'b0, 32'h1, 2'd0, 32'h2, 2'd0));
            step($sformatf("b%0d_fwd", r), 1'b0, mk(1'b1, 32'h33, 2'd3, 32'h2, 2'd0));
            chk($sformatf("b%0d_cnt", r), o_cnt, (r == 0) ? 32'd2 : 32'd3);
        end

        // Younger non-load writer shadows the older load
        drive(1'b1, 5'd7, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0);
        step("sh_lw", 1'b0, mk(1'b1, 32'h1, 2'd0, 32'h2, 2'd0));
        drive(1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
        step("sh_add", 1'b0, mk(1'b1, 32'h1, 2'd0, 32'h2, 2'd0));
        drive(1'b1, 5'd12, 1'b1, 1'b0, 1'b1, 5'd7, 1'b0, 5'd0);
        step("sh_use", 1'b0, mk(1'b1, 32'h11, 2'd1, 32'h2, 2'd0));
        chk("sh_cnt", o_cnt, 32'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
